// File: rtl/ocs_video_pkg.sv
// ocs_video_pkg: shared video types, RGB565 field positions and 640x480 timing constants.
package ocs_video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_UNDERRUN = 2'd2
    } state_t;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int COORD_W  = $clog2(H_ACTIVE > V_ACTIVE ? H_ACTIVE : V_ACTIVE);

    // Replicating the MSB keeps full-scale 5-bit values at full-scale 6-bit.
    function automatic logic [5:0] widen5(input logic [4:0] v);
        return {v, v[4]};
    endfunction

endpackage

// File: rtl/rgb565_to_rgb666.sv
// rgb565_to_rgb666: combinational RGB565 to packed {r6,g6,b6} expansion.
module rgb565_to_rgb666
    import ocs_video_pkg::*;
(
    input  logic [15:0] rgb565,
    output logic [17:0] rgb666
);

    assign rgb666 = {widen5(rgb565[R_MSB:R_LSB]), rgb565[G_MSB:G_LSB], widen5(rgb565[B_MSB:B_LSB])};

endmodule

// File: rtl/ocs_pixel_unpack.sv
// ocs_pixel_unpack: pulls RGB565 words from the video FIFO per active pixel,
// expands them to RGB666 and outputs colour/syncs two pixel clocks after timing.
module ocs_pixel_unpack
    import ocs_video_pkg::*;
#(
    parameter bit          SYNC_ACTIVE_HIGH = 1'b0,
    parameter logic [17:0] UNDERRUN_RGB     = 18'h3F03F
) (
    input  logic               pixel_clk,
    input  logic               rst,
    input  logic               de,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [COORD_W-1:0] sx,
    input  logic [COORD_W-1:0] sy,
    input  logic [15:0]        fifo_dout,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    input  logic               clr_stats,
    output logic [5:0]         vga_r,
    output logic [5:0]         vga_g,
    output logic [5:0]         vga_b,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic [15:0]        underrun_cnt,
    output logic               underrun_flag
);

    state_t      state;
    state_t      state_nx;
    logic        frame_start;
    logic        underrun_ev;
    logic        rd_q;
    logic        ur_q;
    logic        hs_q;
    logic        vs_q;
    logic [17:0] pix_rgb;

    rgb565_to_rgb666 u_expand (
        .rgb565 (fifo_dout),
        .rgb666 (pix_rgb)
    );

    // Outside ACTIVE, only a frame start with data may (re)start reading.
    always_comb begin
        frame_start = de && sx == '0 && sy == '0;
        fifo_rd_en  = !rst && !fifo_empty && (state == ST_ACTIVE ? de : frame_start);
        underrun_ev = state == ST_ACTIVE && de && fifo_empty;
        state_nx    = fifo_rd_en ? ST_ACTIVE : underrun_ev ? ST_UNDERRUN : state;
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state                 <= ST_IDLE;
            rd_q                  <= 1'b0;
            ur_q                  <= 1'b0;
            hs_q                  <= 1'b0;
            vs_q                  <= 1'b0;
            {vga_r, vga_g, vga_b} <= '0;
            vga_hsync             <= !SYNC_ACTIVE_HIGH;
            vga_vsync             <= !SYNC_ACTIVE_HIGH;
        end else begin
            state                 <= state_nx;
            rd_q                  <= fifo_rd_en;
            ur_q                  <= de && !fifo_rd_en && (state == ST_UNDERRUN || underrun_ev);
            hs_q                  <= hsync;
            vs_q                  <= vsync;
            {vga_r, vga_g, vga_b} <= rd_q ? pix_rgb : ur_q ? UNDERRUN_RGB : '0;
            vga_hsync             <= hs_q ^ !SYNC_ACTIVE_HIGH;
            vga_vsync             <= vs_q ^ !SYNC_ACTIVE_HIGH;
        end
    end

    // A clear coinciding with an underrun keeps that underrun.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            underrun_cnt  <= '0;
            underrun_flag <= 1'b0;
        end else if (clr_stats) begin
            underrun_cnt  <= {15'd0, underrun_ev};
            underrun_flag <= underrun_ev;
        end else if (underrun_ev) begin
            underrun_cnt  <= underrun_cnt + {15'd0, underrun_cnt != 16'hFFFF};
            underrun_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ocs_pixel_unpack.sv
// tb_ocs_pixel_unpack: directed frames on a reduced raster driving both sync polarities.
module tb_ocs_pixel_unpack;

    localparam int H_TOT = 11;
    localparam int H_ACT = 8;
    localparam int V_TOT = 6;
    localparam int V_ACT = 4;
    localparam int N     = H_TOT * V_TOT;
    localparam int NONE  = 1000;
    localparam logic [17:0] MAG     = 18'h3F03F;
    localparam logic [19:0] RST_EXP = 20'h0;

    logic        pixel_clk = 1'b0;
    logic        rst, de, hsync, vsync, fifo_empty, clr_stats;
    logic [9:0]  sx, sy;
    logic [15:0] fifo_dout;
    logic        fifo_rd_en, h_rd;
    logic [5:0]  vga_r, vga_g, vga_b, h_r, h_g, h_b;
    logic        vga_hsync, vga_vsync, h_hsync, h_vsync;
    logic [15:0] underrun_cnt, h_cnt;
    logic        underrun_flag, h_flag;

    int          checks = 0;
    int          errors = 0;
    int          fifo_cnt;
    int          reads;
    logic [15:0] word;
    logic [19:0] exp_prev;

    ocs_pixel_unpack #(.SYNC_ACTIVE_HIGH(1'b0)) dut (
        .pixel_clk(pixel_clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync),
        .sx(sx), .sy(sy), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .clr_stats(clr_stats),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .underrun_cnt(underrun_cnt), .underrun_flag(underrun_flag)
    );

    ocs_pixel_unpack #(.SYNC_ACTIVE_HIGH(1'b1)) dut_h (
        .pixel_clk(pixel_clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync),
        .sx(sx), .sy(sy), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(h_rd), .clr_stats(clr_stats),
        .vga_r(h_r), .vga_g(h_g), .vga_b(h_b),
        .vga_hsync(h_hsync), .vga_vsync(h_vsync),
        .underrun_cnt(h_cnt), .underrun_flag(h_flag)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // kind: 0 black (idle), 1 reading, 2 magenta (underrun carried in)
    task automatic frame(input int kind, input logic [15:0] w, input logic [17:0] exp_rgb,
                         input int fill, input int fail_c, input int clr_c, input int rst_c,
                         input int exp_reads);
        int          ph;
        logic        exp_rd;
        logic        rd;
        logic [19:0] exp_cur;
        ph       = kind;
        fifo_cnt = fill;
        word     = w;
        reads    = 0;
        for (int c = 0; c < N; c++) begin
            sx         = 10'(c % H_TOT);
            sy         = 10'(c / H_TOT);
            de         = (c % H_TOT < H_ACT) && (c / H_TOT < V_ACT);
            hsync      = (c % H_TOT) == 9;
            vsync      = (c / H_TOT) == 5;
            fifo_empty = fifo_cnt == 0 || c >= fail_c;
            clr_stats  = c == clr_c;
            rst        = c == rst_c;
            if (rst) ph = 0;
            if (ph == 1 && de && fifo_empty) ph = 2;
            exp_rd  = ph == 1 && de;
            exp_cur = rst ? RST_EXP : {de ? (ph == 1 ? exp_rgb : ph == 2 ? MAG : 18'h0) : 18'h0, hsync, vsync};
            if (rst) exp_prev = RST_EXP;
            #1;
            rd = fifo_rd_en;
            chk("rd_en", {62'd0, fifo_rd_en, h_rd}, {62'd0, exp_rd, exp_rd});
            @(posedge pixel_clk);
            #1;
            chk("pixel", {vga_r, vga_g, vga_b, h_r, h_g, h_b, vga_hsync, vga_vsync, h_hsync, h_vsync},
                {exp_prev[19:2], exp_prev[19:2], ~exp_prev[1:0], exp_prev[1:0]});
            if (rd) begin
                fifo_cnt--;
                reads++;
                fifo_dout = word;
            end else begin
                fifo_dout = 16'hDEAD;
            end
            exp_prev = exp_cur;
        end
        chk("reads", 64'(reads), 64'(exp_reads));
    endtask

    task automatic stats(input logic [15:0] cnt, input logic flag);
        chk("underrun_cnt", {48'd0, underrun_cnt}, {48'd0, cnt});
        chk("underrun_flag", {63'd0, underrun_flag}, {63'd0, flag});
    endtask

    initial begin
        rst        = 1'b1;
        de         = 1'b0;
        hsync      = 1'b0;
        vsync      = 1'b0;
        sx         = '0;
        sy         = '0;
        fifo_empty = 1'b1;
        clr_stats  = 1'b0;
        fifo_dout  = 16'h0;
        exp_prev   = RST_EXP;
        repeat (3) @(posedge pixel_clk);
        #1;
        chk("rst_rgb", {vga_r, vga_g, vga_b, h_r, h_g, h_b}, 64'h0);
        chk("rst_sync", {vga_hsync, vga_vsync, h_hsync, h_vsync}, 64'b1100);
        chk("rst_stats", {h_cnt, h_flag, underrun_cnt, underrun_flag}, 64'h0);
        chk("rst_rd", {fifo_rd_en, h_rd}, 64'h0);
        stats(16'h0, 1'b0);

        frame(0, 16'h0000, 18'h0, 0, NONE, NONE, NONE, 0);
        stats(16'h0, 1'b0);
        frame(1, 16'hF800, 18'h3F000, 32, NONE, NONE, NONE, 32);
        stats(16'h0, 1'b0);
        frame(1, 16'h8410, 18'h21821, 32, 14, NONE, NONE, 11);
        stats(16'h1, 1'b1);
        frame(2, 16'h0000, 18'h0, 0, NONE, NONE, NONE, 0);
        stats(16'h1, 1'b1);
        frame(1, 16'hFFFF, 18'h3FFFF, 32, NONE, NONE, NONE, 32);
        stats(16'h1, 1'b1);

        force dut.underrun_cnt = 16'hFFFE;
        #1;
        release dut.underrun_cnt;
        chk("cnt_preset", {48'd0, underrun_cnt}, 64'hFFFE);
        frame(1, 16'h0000, 18'h0, 0, 0, NONE, NONE, 0);
        stats(16'hFFFF, 1'b1);
        frame(1, 16'h8410, 18'h21821, 4, 4, NONE, NONE, 4);
        stats(16'hFFFF, 1'b1);
        frame(1, 16'h07E0, 18'h00FC0, 4, 4, NONE, NONE, 4);
        stats(16'hFFFF, 1'b1);
        frame(1, 16'h001F, 18'h0003F, 4, 4, 4, NONE, 4);
        stats(16'h1, 1'b1);
        frame(2, 16'h0000, 18'h0, 0, NONE, NONE, NONE, 0);
        stats(16'h1, 1'b1);

        frame(1, 16'h07E0, 18'h00FC0, 32, NONE, NONE, 25, 19);
        stats(16'h0, 1'b0);
        frame(1, 16'h001F, 18'h0003F, 32, NONE, NONE, NONE, 32);
        stats(16'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ocs_pixel_unpack.md
OCS_PIXEL_UNPACK -- requirements
Module: ocs_pixel_unpack

Interface
REQ-001 SHALL have parameter SYNC_ACTIVE_HIGH, default 0, meaning vga_hsync/vga_vsync output polarity; 0 = active-low.
REQ-002 SHALL have parameter UNDERRUN_RGB, 18-bit, default 18'h3F03F (magenta), meaning the colour shown on active pixels after an underrun.
REQ-003 pixel_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 de  in  1  display-enable from the 640x480 timing generator.
REQ-006 hsync, vsync  in  1 each  active-high syncs from the timing generator.
REQ-007 sx, sy  in  10 each  current screen coordinates.
REQ-008 fifo_dout  in  16  RGB565 word: R[15:11], G[10:5], B[4:0]; valid 1 cycle after fifo_rd_en.
REQ-009 fifo_empty  in  1  video FIFO empty flag.
REQ-010 fifo_rd_en  out  1  FIFO read strobe, combinational.
REQ-011 clr_stats  in  1  single-cycle pulse clearing underrun statistics.
REQ-012 vga_r, vga_g, vga_b  out  6 each  registered pixel colour.
REQ-013 vga_hsync, vga_vsync  out  1 each  registered syncs, polarity per SYNC_ACTIVE_HIGH.
REQ-014 underrun_cnt  out  16  saturating count of underrun events.
REQ-015 underrun_flag  out  1  sticky: at least one underrun since reset/clr_stats.

Function
REQ-016 States: IDLE, ACTIVE, UNDERRUN.
REQ-017 Frame start = de && sx==0 && sy==0.
REQ-018 IDLE: fifo_rd_en=0; at frame start with !fifo_empty -> ACTIVE and fifo_rd_en=1 that cycle; at frame start with fifo_empty, stays IDLE, no count.
REQ-019 ACTIVE: fifo_rd_en = de && !fifo_empty; de && fifo_empty -> UNDERRUN, underrun_cnt +1, underrun_flag set.
REQ-020 UNDERRUN: fifo_rd_en=0 except at frame start with !fifo_empty, which behaves as REQ-018 (read, -> ACTIVE); at frame start with fifo_empty, stays UNDERRUN, no extra count.
REQ-021 Colour selection, one cycle after inputs: pixel read -> expanded fifo_dout; de in UNDERRUN (including the failing cycle) -> UNDERRUN_RGB; otherwise 0.
REQ-022 Expansion: r6={R5,R5[4]}, g6=G6, b6={B5,B5[4]}; 16'hFFFF -> all 6'h3F.
REQ-023 Latency: vga_r/g/b/hsync/vsync appear exactly 2 pixel_clk cycles after the corresponding de/hsync/vsync/sx/sy input; syncs and colour stay aligned.
REQ-024 underrun_cnt saturates at 16'hFFFF.
REQ-025 clr_stats zeroes underrun_cnt and underrun_flag; clr_stats coincident with an underrun yields cnt=1, flag=1.
REQ-026 Exactly one FIFO word consumed per active pixel in ACTIVE; no read while fifo_empty=1.

Reset
REQ-027 rst: state=IDLE, pipeline de/read bits cleared, vga_r/g/b=0, syncs inactive per polarity, underrun_cnt=0, underrun_flag=0.
REQ-028 rst mid-frame takes effect next edge; no reads until the next frame start.

Structure
REQ-029 Package ocs_video_pkg holds the state enum, RGB565 field positions, and 640x480 constants (H_ACTIVE=640, V_ACTIVE=480).
REQ-030 One sub-module, rgb565_to_rgb666 (combinational expansion); everything else lives in ocs_pixel_unpack.

Verification
REQ-031 Reset, FIFO preloaded with 640*480 words of 16'hF800 -> reads start at frame start; vga_r=6'h3F, g=b=0 on every active pixel 2 cycles after de; 307200 reads.
REQ-032 FIFO empty at first frame start, filled before the next -> IDLE for frame 1 (black, cnt=0); ACTIVE from frame 2.
REQ-033 Empty asserted at sx=100, sy=10 in ACTIVE -> cnt=1, flag=1; that pixel and remaining active pixels = 18'h3F03F; no reads until the next frame start.
REQ-034 Force cnt to 16'hFFFE, cause 3 underruns -> cnt=16'hFFFF; then clr_stats coincident with an underrun -> cnt=1, flag=1.
REQ-035 SYNC_ACTIVE_HIGH=0 vs 1 -> vga_hsync equals inverted/non-inverted hsync delayed 2 cycles; after rst, syncs inactive and colour 0.
REQ-036 rst asserted at sy=200 -> next-cycle outputs at reset values; fifo_rd_en=0 until sx=0, sy=0 with de.
